// File: rtl/fetch_pipe_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and an
// advance-tick generator. The tick comes either from a free-running divider
// or from a synchronised single-step request.
module fetch_pipe_stage #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                DIV_MAX  = 0,
    parameter int                CNT_W    = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Stall,
    input  logic              Flush,
    input  logic              BranchTaken,
    input  logic [ADDR_W-1:0] BranchTarget,
    input  logic              StepMode,
    input  logic              StepReq,
    output logic [ADDR_W-1:0] IMemAddr,
    input  logic [DATA_W-1:0] IMemData,
    output logic [ADDR_W-1:0] PCResult,
    output logic [DATA_W-1:0] IF_ID_Instr,
    output logic [ADDR_W-1:0] IF_ID_PCPlus4,
    output logic              IF_ID_Valid,
    output logic              Tick,
    output logic [CNT_W-1:0]  InstrCount
);

    // A zero terminal count still needs a one-bit counter to keep widths legal.
    localparam int                DIV_W  = (DIV_MAX > 0) ? $clog2(DIV_MAX + 1) : 1;
    localparam logic [DIV_W-1:0]  DIV_TC = DIV_W'(DIV_MAX);
    localparam logic [ADDR_W-1:0] PC_RST = {RESET_PC[ADDR_W-1:2], 2'b00};

    // ------------------------------------------------------------------
    // Tick generation state
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_cnt_reg,   div_cnt_next;
    logic             tick_reg,      tick_next;
    logic             mode_prev_reg;
    logic             step_sync1_reg;
    logic             step_sync2_reg;
    logic             step_edge_reg;

    logic             mode_change;
    logic             step_rise;
    logic             div_terminal;

    // ------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] pc_reg,     pc_next;
    logic [DATA_W-1:0] instr_reg,  instr_next;
    logic [ADDR_W-1:0] pcp4_reg,   pcp4_next;
    logic              valid_reg,  valid_next;
    logic [CNT_W-1:0]  cnt_reg,    cnt_next;

    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] branch_pc;
    logic              advance;
    logic              issue;

    // The low two target bits are discarded by design; keep them visibly consumed.
    logic unused_target_bits;
    assign unused_target_bits = ^BranchTarget[1:0];

    assign mode_change  = (StepMode != mode_prev_reg);
    assign step_rise    = step_sync2_reg & ~step_edge_reg;
    assign div_terminal = (div_cnt_reg == DIV_TC);

    // Divider restarts on any mode switch and parks at zero in step mode.
    always_comb begin
        div_cnt_next = div_cnt_reg + 1'b1;
        if (StepMode || mode_change || div_terminal) begin
            div_cnt_next = '0;
        end
    end

    // Registered tick: a mode switch suppresses the pulse for that cycle.
    always_comb begin
        tick_next = 1'b0;
        if (!mode_change) begin
            tick_next = StepMode ? step_rise : div_terminal;
        end
    end

    // Divider, tick and mode-history registers.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            div_cnt_reg   <= '0;
            tick_reg      <= 1'b0;
            mode_prev_reg <= 1'b0;
        end else begin
            div_cnt_reg   <= div_cnt_next;
            tick_reg      <= tick_next;
            mode_prev_reg <= StepMode;
        end
    end

    // Two-flop synchroniser for the asynchronous step request, then edge history.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            step_sync1_reg <= 1'b0;
            step_sync2_reg <= 1'b0;
            step_edge_reg  <= 1'b0;
        end else begin
            step_sync1_reg <= StepReq;
            step_sync2_reg <= step_sync1_reg;
            step_edge_reg  <= step_sync2_reg;
        end
    end

    // ------------------------------------------------------------------
    // PC / IF/ID next-state
    // ------------------------------------------------------------------
    assign pc_plus4  = pc_reg + ADDR_W'(4);
    assign branch_pc = {BranchTarget[ADDR_W-1:2], 2'b00};
    assign advance   = tick_reg;
    assign issue     = advance & ~BranchTaken & ~Flush & ~Stall;

    // Priority: branch redirect, then flush, then stall, then normal fetch.
    always_comb begin
        pc_next    = pc_reg;
        instr_next = instr_reg;
        pcp4_next  = pcp4_reg;
        valid_next = valid_reg;
        if (advance) begin
            if (BranchTaken) begin
                pc_next    = branch_pc;
                instr_next = '0;
                pcp4_next  = '0;
                valid_next = 1'b0;
            end else if (Flush) begin
                instr_next = '0;
                pcp4_next  = '0;
                valid_next = 1'b0;
                if (!Stall) begin
                    pc_next = pc_plus4;
                end
            end else if (!Stall) begin
                pc_next    = pc_plus4;
                instr_next = IMemData;
                pcp4_next  = pc_plus4;
                valid_next = 1'b1;
            end
        end
    end

    // Issued-instruction counter saturates instead of wrapping.
    always_comb begin
        cnt_next = cnt_reg;
        if (issue && (cnt_reg != {CNT_W{1'b1}})) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    // PC, IF/ID and counter registers.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            pc_reg    <= PC_RST;
            instr_reg <= '0;
            pcp4_reg  <= '0;
            valid_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            pc_reg    <= pc_next;
            instr_reg <= instr_next;
            pcp4_reg  <= pcp4_next;
            valid_reg <= valid_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign IMemAddr      = pc_reg;
    assign PCResult      = pc_reg;
    assign IF_ID_Instr   = instr_reg;
    assign IF_ID_PCPlus4 = pcp4_reg;
    assign IF_ID_Valid   = valid_reg;
    assign Tick          = tick_reg;
    assign InstrCount    = cnt_reg;

endmodule
